// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store initiator for the word-organised data memory; sub-word stores use read-modify-write.
// Optional DMEM_ALIGN_CHECK_EN: misaligned word/half accesses fault instead of having their low address bits masked.
module dmem_access_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_ena,
   output logic        mem_wena,
   output logic        mem_r_cs,
   output logic        mem_w_cs,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LH  = 3'b001,
      OP_LW  = 3'b010,
      OP_LBU = 3'b011,
      OP_LHU = 3'b100,
      OP_SB  = 3'b101,
      OP_SH  = 3'b110,
      OP_SW  = 3'b111
   } op_t;

   localparam logic [31:0] SPAN = 32'(4 * DEPTH);

   state_t      state;
   op_t         op_q;
   logic [31:0] addr_q;
   logic [15:0] wdata_q;

   op_t         req_op_e;
   logic        is_word;
   logic        is_half;
   logic        misaligned;
   logic        out_of_range;
   logic        fault;
   logic [31:0] eff_addr;
   logic [31:0] offset;

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_data;
   logic [31:0] merged;
   logic        op_is_load;

   always_comb begin
      req_op_e     = op_t'(req_op);
      is_word      = (req_op_e == OP_LW) || (req_op_e == OP_SW);
      is_half      = (req_op_e == OP_LH) || (req_op_e == OP_LHU) || (req_op_e == OP_SH);
      offset       = req_addr - BASE_ADDR;
      out_of_range = (req_addr < BASE_ADDR) || (offset >= SPAN);
`ifdef DMEM_ALIGN_CHECK_EN
      eff_addr     = req_addr;
      misaligned   = is_word ? (req_addr[1:0] != 2'b00) :
                     is_half ? req_addr[0] : 1'b0;
`else
      eff_addr     = req_addr;
      misaligned   = 1'b0;
      if (is_word) eff_addr[1:0] = 2'b00;
      if (is_half) eff_addr[0]   = 1'b0;
`endif
      fault        = out_of_range || misaligned;
   end

   always_comb begin
      case (addr_q[1:0])
         2'd0:    rd_byte = mem_rdata[7:0];
         2'd1:    rd_byte = mem_rdata[15:8];
         2'd2:    rd_byte = mem_rdata[23:16];
         default: rd_byte = mem_rdata[31:24];
      endcase
      rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      case (op_q)
         OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
         OP_LBU:  load_data = {24'h0, rd_byte};
         OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
         OP_LHU:  load_data = {16'h0, rd_half};
         default: load_data = mem_rdata;
      endcase

      merged = mem_rdata;
      if (op_q == OP_SB) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (op_q == OP_SH) begin
         if (addr_q[1]) merged[31:16] = wdata_q;
         else           merged[15:0]  = wdata_q;
      end

      op_is_load = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW) ||
                   (op_q == OP_LBU) || (op_q == OP_LHU);
   end

   // Memory controls are registered one state ahead so they are valid for the whole READ/WRITE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_q       <= OP_LB;
         addr_q     <= '0;
         wdata_q    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_ena    <= 1'b0;
         mem_wena   <= 1'b0;
         mem_r_cs   <= 1'b0;
         mem_w_cs   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op_e;
                  addr_q    <= eff_addr;
                  wdata_q   <= req_wdata[15:0];
                  req_ready <= 1'b0;
                  if (fault) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (req_op_e == OP_SW) begin
                     state     <= WRITE;
                     mem_ena   <= 1'b1;
                     mem_wena  <= 1'b1;
                     mem_w_cs  <= 1'b1;
                     mem_addr  <= {eff_addr[31:2], 2'b00};
                     mem_wdata <= req_wdata;
                  end else begin
                     state    <= READ;
                     mem_ena  <= 1'b1;
                     mem_r_cs <= 1'b1;
                     mem_addr <= {eff_addr[31:2], 2'b00};
                  end
               end
            end
            READ: begin
               mem_r_cs <= 1'b0;
               if (op_is_load) begin
                  state      <= RESP;
                  mem_ena    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_data;
               end else begin
                  state     <= WRITE;
                  mem_wena  <= 1'b1;
                  mem_w_cs  <= 1'b1;
                  mem_addr  <= {addr_q[31:2], 2'b00};
                  mem_wdata <= merged;
               end
            end
            WRITE: begin
               state      <= RESP;
               mem_ena    <= 1'b0;
               mem_wena   <= 1'b0;
               mem_w_cs   <= 1'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus random requests against an arithmetic reference model.
module tb_dmem_access_ctrl;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_ena;
   logic        mem_wena;
   logic        mem_r_cs;
   logic        mem_w_cs;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] last_waddr;
   logic [31:0] last_wdata;
   logic [31:0] last_rdata;
   logic        last_err;

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   bit          init_done;
   logic [31:0] moff;

   dmem_access_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_r_cs(mem_r_cs), .mem_w_cs(mem_w_cs),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] seed_word(input int unsigned i);
      return (i * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   // Behavioural memory: combinational read, write committed at the clock edge.
   assign moff = mem_addr - BASE;
   always_comb begin
      mem_rdata = '0;
      if (mem_addr >= BASE && moff < SPAN) mem_rdata = mem[moff[11:2]];
   end

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= seed_word(i);
         init_done <= 1'b1;
      end else if (mem_ena && mem_wena && mem_w_cs && mem_addr >= BASE && moff < SPAN) begin
         mem[moff[11:2]] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model: computes the architectural result and updates ref_mem.
   task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd,
                        output int lat, output int nrd, output int nwr);
      longint      a;
      logic [31:0] ea, word, b, h, mask, idx;
      int unsigned sh;
      bit          is_word, is_half, mis;
      a       = longint'(addr);
      is_word = (op == 3'd2) || (op == 3'd7);
      is_half = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      mis     = ALIGN && ((is_word && addr % 4 != 0) || (is_half && addr % 2 != 0));
      err     = (a < longint'(BASE)) || (a >= longint'(BASE) + longint'(SPAN)) || mis;
      rd = '0; nrd = 0; nwr = 0;
      if (err) begin
         lat = 1;
         return;
      end
      ea = addr;
      if (is_word) ea = addr - addr % 4;
      if (is_half) ea = addr - addr % 2;
      idx  = (ea - BASE) / 4;
      sh   = ea % 4;
      word = ref_mem[idx[9:0]];
      b    = (word >> (8 * sh)) & 32'hFF;
      h    = (word >> (8 * (sh & 2))) & 32'hFFFF;
      lat  = (op == 3'd5 || op == 3'd6) ? 3 : 2;
      nrd  = (op == 3'd7) ? 0 : 1;
      nwr  = (op >= 3'd5) ? 1 : 0;
      case (op)
         3'd0: rd = b | ((b >= 128) ? 32'hFFFF_FF00 : 32'h0);
         3'd1: rd = h | ((h >= 32768) ? 32'hFFFF_0000 : 32'h0);
         3'd2: rd = word;
         3'd3: rd = b;
         3'd4: rd = h;
         3'd5: begin
            mask = 32'hFF << (8 * sh);
            ref_mem[idx[9:0]] = (word & ~mask) | ((wd & 32'hFF) << (8 * sh));
         end
         3'd6: begin
            mask = 32'hFFFF << (8 * sh);
            ref_mem[idx[9:0]] = (word & ~mask) | ((wd & 32'hFFFF) << (8 * sh));
         end
         default: ref_mem[idx[9:0]] = wd;
      endcase
   endtask

   task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input string tag);
      int          cyc, lat, nrd, nwr, nany, e_lat, e_nrd, e_nwr;
      logic        e_err, overlap;
      logic [31:0] e_rd;
      cyc = 0;
      @(negedge clk);
      while (!req_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (!req_ready) check({tag, "_ready_timeout"}, {31'h0, req_ready}, 32'h1);
      model(op, addr, wd, e_err, e_rd, e_lat, e_nrd, e_nwr);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      lat = 1; nrd = 0; nwr = 0; nany = 0; overlap = 1'b0;
      while (!resp_valid && lat < 10) begin
         if (mem_ena || mem_wena || mem_r_cs || mem_w_cs) nany++;
         if (mem_ena && mem_r_cs) nrd++;
         if (mem_ena && mem_wena && mem_w_cs) begin
            nwr++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
         end
         if (mem_wena && mem_r_cs) overlap = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      if (mem_ena || mem_wena || mem_r_cs || mem_w_cs) nany++;
      last_rdata = resp_rdata;
      last_err   = resp_err;
      check({tag, "_latency"}, lat, e_lat);
      check({tag, "_err"}, {31'h0, resp_err}, {31'h0, e_err});
      check({tag, "_rdata"}, resp_rdata, e_rd);
      check({tag, "_reads"}, nrd, e_nrd);
      check({tag, "_writes"}, nwr, e_nwr);
      check({tag, "_ctrl_cycles"}, nany, e_nrd + e_nwr);
      check({tag, "_wena_rcs"}, {31'h0, overlap}, 32'h0);
      @(posedge clk);
      #1;
      check({tag, "_resp_pulse"}, {31'h0, resp_valid}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int unsigned sel;
      logic [31:0] a;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_ctrls", {28'h0, mem_ena, mem_wena, mem_r_cs, mem_w_cs}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;

      do_req(3'd7, 32'h1001_0010, 32'hDEAD_BEEF, "sw");
      check("sw_waddr", last_waddr, 32'h1001_0010);
      check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
      do_req(3'd2, 32'h1001_0010, 32'h0, "lw");
      check("lw_const", last_rdata, 32'hDEAD_BEEF);
      do_req(3'd5, 32'h1001_0012, 32'h0000_0055, "sb");
      check("sb_wdata", last_wdata, 32'hDE55_BEEF);
      do_req(3'd0, 32'h1001_0013, 32'h0, "lb");
      check("lb_const", last_rdata, 32'hFFFF_FFDE);
      do_req(3'd3, 32'h1001_0013, 32'h0, "lbu");
      check("lbu_const", last_rdata, 32'h0000_00DE);
      do_req(3'd1, 32'h1001_0010, 32'h0, "lh");
      check("lh_const", last_rdata, 32'hFFFF_BEEF);
      do_req(3'd4, 32'h1001_0010, 32'h0, "lhu");
      check("lhu_const", last_rdata, 32'h0000_BEEF);
      do_req(3'd2, 32'h1000_FFFC, 32'h0, "lw_below");
      check("lw_below_err", {31'h0, last_err}, 32'h1);
      do_req(3'd7, 32'h1001_1000, 32'h1234_5678, "sw_above");
      check("sw_above_err", {31'h0, last_err}, 32'h1);
      do_req(3'd2, 32'h1001_0FFC, 32'h0, "lw_top");
      do_req(3'd2, 32'h1001_0011, 32'h0, "lw_misal");
      if (ALIGN) check("misal_err", {31'h0, last_err}, 32'h1);
      else       check("misal_word", last_rdata, 32'hDE55_BEEF);

      // SH aborted by reset during its WRITE cycle.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 3'd6;
      req_addr  = 32'h1001_0010;
      req_wdata = 32'h0000_1234;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("abort_read_cycle", {31'h0, mem_r_cs}, 32'h1);
      @(posedge clk);
      #1;
      check("abort_wena_before", {31'h0, mem_wena}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_wena_dropped", {31'h0, mem_wena}, 32'h0);
      check("abort_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      do_req(3'd2, 32'h1001_0010, 32'h0, "lw_after_abort");
      check("abort_word_kept", last_rdata, 32'hDE55_BEEF);

      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 11);
         if (sel == 0)      a = BASE - 4 * $urandom_range(1, 16) + $urandom_range(0, 3);
         else if (sel == 1) a = BASE + SPAN + $urandom_range(0, 255);
         else if (sel == 2) a = BASE + SPAN - 4 + $urandom_range(0, 3);
         else               a = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
         do_req(3'($urandom_range(0, 7)), a, $urandom, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
